// File: rtl/ifetch_responder_if.sv
// Fetch-side and memory-side handshake bundle for ifetch_responder.
// The slave modport is the responder's view; the master modport is the view
// of whoever drives requests and plays the memory (CPU front end plus memory).
interface ifetch_responder_if;
  // Fetch request channel
  logic        valid;
  logic [31:0] iaddr;
  logic        uncached;
  logic        addr_ok;
  logic        cancel;

  // Fetch response channel
  logic        data_ok;
  logic [31:0] rdata;
  logic [31:0] resp_addr;
  logic        resp_ready;

  // Memory address channel
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_uncached;
  logic        mem_gnt;

  // Memory data channel (in order, no backpressure)
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  valid, iaddr, uncached, cancel, resp_ready,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output addr_ok, data_ok, rdata, resp_addr,
    output mem_req, mem_addr, mem_uncached
  );

  modport master (
    output valid, iaddr, uncached, cancel, resp_ready,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  addr_ok, data_ok, rdata, resp_addr,
    input  mem_req, mem_addr, mem_uncached
  );
endinterface

// File: rtl/ifetch_responder.sv
// Instruction-fetch responder: forwards fetch requests to memory, tracks up
// to DEPTH outstanding fetches in an in-order FIFO, and returns words to the
// consumer in request order. A flush marks outstanding fetches as cancelled;
// their data is still absorbed from memory and then silently discarded.
module ifetch_responder #(
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  ifetch_responder_if.slave io_bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  // Tracking FIFO storage
  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [DEPTH-1:0] r_canc;
  logic [DEPTH-1:0] r_has;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_cnt;

  // Control wires
  logic             w_full;
  logic             w_mem_req;
  logic             w_addr_ok;
  logic             w_push;
  logic             w_head_occ;
  logic             w_head_has;
  logic             w_head_canc;
  logic             w_data_ok;
  logic             w_pop;
  logic [DEPTH-1:0] w_occ;
  logic             w_wr_hit;
  logic [PW-1:0]    w_wr_idx;
  logic             w_wr_en;

  // Advance a FIFO pointer, wrapping at DEPTH (DEPTH need not be a power of two)
  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    if (32'(p) == DEPTH - 1) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // Request side: accept only while a tracking slot is free at the start of the cycle
  assign w_full     = (r_cnt == CW'(DEPTH));
  assign w_mem_req  = io_bus.valid & ~io_bus.cancel & ~rst & ~w_full;
  assign w_addr_ok  = w_mem_req & io_bus.mem_gnt;
  assign w_push     = io_bus.valid & w_addr_ok;

  // Response side: only registered head state reaches data_ok/rdata
  assign w_head_occ  = (r_cnt != '0);
  assign w_head_has  = r_has[r_head];
  assign w_head_canc = r_canc[r_head];
  assign w_data_ok   = w_head_occ & w_head_has & ~w_head_canc & ~io_bus.cancel & ~rst;
  assign w_pop       = (w_data_ok & io_bus.resp_ready) |
                       (w_head_occ & w_head_canc & w_head_has);

  // Return data lands in the oldest occupied entry still waiting for its word
  assign w_wr_en = io_bus.mem_rvalid & w_wr_hit;

  assign io_bus.mem_req      = w_mem_req;
  assign io_bus.mem_addr     = io_bus.iaddr;
  assign io_bus.mem_uncached = io_bus.uncached;
  assign io_bus.addr_ok      = w_addr_ok;
  assign io_bus.data_ok      = w_data_ok;
  assign io_bus.rdata        = r_data[r_head];
  assign io_bus.resp_addr    = r_addr[r_head];

  // Walk the FIFO from head: build the occupancy mask and find the data-write target
  always_comb begin
    int unsigned v_slot;
    v_slot   = 0;
    w_occ    = '0;
    w_wr_hit = 1'b0;
    w_wr_idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      v_slot = 32'(r_head) + k;
      if (v_slot >= DEPTH) begin
        v_slot = v_slot - DEPTH;
      end
      if (k < 32'(r_cnt)) begin
        w_occ[PW'(v_slot)] = 1'b1;
        if (!w_wr_hit && !r_has[PW'(v_slot)]) begin
          w_wr_hit = 1'b1;
          w_wr_idx = PW'(v_slot);
        end
      end
    end
  end

  // Pointer and occupancy bookkeeping; push, data-write and pop may all coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_tail <= f_inc(r_tail);
      end
      if (w_pop) begin
        r_head <= f_inc(r_head);
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Per-entry flags: a flush marks every occupied entry; a push starts a fresh entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_canc <= '0;
      r_has  <= '0;
    end else begin
      if (io_bus.cancel) begin
        r_canc <= r_canc | w_occ;
      end
      if (w_wr_en) begin
        r_has[w_wr_idx] <= 1'b1;
      end
      if (w_push) begin
        r_canc[r_tail] <= 1'b0;
        r_has[r_tail]  <= 1'b0;
      end
    end
  end

  // Entry payloads: address captured on accept, instruction word on return
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_addr[k] <= '0;
        r_data[k] <= '0;
      end
    end else begin
      if (w_wr_en) begin
        r_data[w_wr_idx] <= io_bus.mem_rdata;
      end
      if (w_push) begin
        r_addr[r_tail] <= io_bus.iaddr;
      end
    end
  end

endmodule
